// File: rtl/opb_register_snapshot_bank_pkg.sv
// Shared definitions for the OPB register snapshot bank: register word
// offsets, CTRL bit positions, version constant and counter width.
package opb_register_snapshot_bank_pkg;

  localparam int          CNT_W   = 32;
  localparam logic [15:0] VERSION = 16'h0002;

  // Word offsets (byte address bits [7:2])
  localparam logic [5:0] W_CTRL      = 6'd0;
  localparam logic [5:0] W_STATUS    = 6'd1;
  localparam logic [5:0] W_INFO      = 6'd2;
  localparam logic [5:0] W_CHAN_BASE = 6'd4;

  // CTRL bit indices (LSB numbering)
  localparam int CTRL_SNAP   = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_FREEZE = 2;

  // Per-cycle command broadcast to every channel
  typedef struct packed {
    logic snap;     // copy live data and counter into the snapshots
    logic clear;    // zero live counter and overflow flag
    logic refresh;  // auto-snap: copy live data only
  } chan_cmd_t;

  // Word index of DATA_SNAP[ch]; COUNT_SNAP[ch] is the next word
  function automatic logic [5:0] data_word(input int ch);
    return W_CHAN_BASE + 6'(2 * ch);
  endfunction

  function automatic logic [5:0] count_word(input int ch);
    return data_word(ch) + 6'd1;
  endfunction

  function automatic logic [31:0] info_word(input int num_ch, input int dwidth);
    return {VERSION, 8'(num_ch), 8'(dwidth)};
  endfunction

endpackage

// File: rtl/opb_snap_chan.sv
// One snapshot channel: saturating event counter with sticky overflow,
// plus data and count snapshot registers.
module opb_snap_chan
  import opb_register_snapshot_bank_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  chan_cmd_t         cmd,
  input  logic              valid,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_snap,
  output logic [CNT_W-1:0]  count_snap,
  output logic              overflow
);

  logic [CNT_W-1:0] live_count;
  logic             saturated;

  assign saturated = &live_count;

  // Live counter: clear beats an increment in the same cycle; at saturation
  // the count holds and the overflow flag latches.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_count <= '0;
      overflow   <= 1'b0;
    end else if (cmd.clear) begin
      live_count <= '0;
      overflow   <= 1'b0;
    end else if (valid) begin
      if (saturated) overflow   <= 1'b1;
      else           live_count <= live_count + 1'b1;
    end
  end

  // Snapshots sample the pre-edge live values, so a simultaneous clear
  // still captures the old count.
  // NOTE: snapshot registers are reset explicitly; software must never read
  // stale contents after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_snap  <= '0;
      count_snap <= '0;
    end else begin
      if (cmd.snap)                data_snap  <= data_in;
      else if (cmd.refresh)        data_snap  <= data_in;
      if (cmd.snap)                count_snap <= live_count;
    end
  end

endmodule

// File: rtl/opb_register_snapshot_bank.sv
// OPB slave exposing CTRL/STATUS/INFO and per-channel data/count snapshots.
// Single-cycle registered acknowledge; read data is valid only in the ack
// cycle and zero otherwise.
module opb_register_snapshot_bank
  import opb_register_snapshot_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR  = 32'h01100000,
  parameter logic [31:0] C_HIGHADDR  = 32'h011000FF,
  parameter int          C_NUM_CH    = 4,
  parameter int          C_DWIDTH    = 32,
  parameter int          C_AUTO_SNAP = 0
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  input  logic [0:31]                  OPB_ABus,
  input  logic [0:3]                   OPB_BE,
  input  logic [0:31]                  OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:31]                  Sl_DBus,
  output logic                         Sl_xferAck,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  input  logic [C_NUM_CH*C_DWIDTH-1:0] user_data_in,
  input  logic [C_NUM_CH-1:0]          user_valid
);

  // OPB vectors are MSB-first; these copies use LSB numbering throughout.
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [5:0]  word;
  logic        hit;
  logic        req;
  logic        ctrl_wr;
  logic        freeze;
  logic        xfer_ack;
  logic [31:0] rdata;
  logic [31:0] rd_q;
  chan_cmd_t   cmd;

  logic [C_NUM_CH-1:0] overflow;
  logic [C_DWIDTH-1:0] data_snap  [C_NUM_CH];
  logic [CNT_W-1:0]    count_snap [C_NUM_CH];

  logic unused_inputs;

  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign word  = addr[7:2];
  assign hit   = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  // A new transfer starts only when no ack is outstanding, so a held select
  // is acknowledged on alternate cycles with a fresh decode each time.
  assign req = OPB_select && hit && !xfer_ack;

  // CTRL side effects happen in the ack cycle and need the low byte enabled.
  assign ctrl_wr = xfer_ack && OPB_select && hit && !OPB_RNW &&
                   (word == W_CTRL) && OPB_BE[3];

  assign cmd.snap    = ctrl_wr && wdata[CTRL_SNAP];
  assign cmd.clear   = ctrl_wr && wdata[CTRL_CLEAR];
  assign cmd.refresh = (C_AUTO_SNAP != 0) && !freeze;

  assign Sl_xferAck = xfer_ack;
  assign Sl_DBus    = rd_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:3]};

  // Acknowledge and read-data registers; read data is captured with the
  // request decode so it appears exactly in the ack cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      xfer_ack <= 1'b0;
      rd_q     <= '0;
    end else begin
      xfer_ack <= req;
      rd_q     <= (req && OPB_RNW) ? rdata : '0;
    end
  end

  // Persistent FREEZE bit; SNAP and CLEAR are pulses and are never stored.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst)     freeze <= 1'b0;
    else if (ctrl_wr) freeze <= wdata[CTRL_FREEZE];
  end

  // Read multiplexer over the register map; unmapped words read zero.
  // NOTE: rdata gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    unique case (word)
      W_CTRL:   rdata[CTRL_FREEZE]     = freeze;
      W_STATUS: rdata[C_NUM_CH-1:0]    = overflow;
      W_INFO:   rdata                  = info_word(C_NUM_CH, C_DWIDTH);
      default: begin
        for (int i = 0; i < C_NUM_CH; i++) begin
          if (word == data_word(i))  rdata = 32'(data_snap[i]);
          if (word == count_word(i)) rdata = count_snap[i];
        end
      end
    endcase
  end

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_chan
    opb_snap_chan #(
      .DWIDTH (C_DWIDTH)
    ) u_chan (
      .clk        (OPB_Clk),
      .rst_n      (OPB_Rst),
      .cmd        (cmd),
      .valid      (user_valid[i]),
      .data_in    (user_data_in[i*C_DWIDTH +: C_DWIDTH]),
      .data_snap  (data_snap[i]),
      .count_snap (count_snap[i]),
      .overflow   (overflow[i])
    );
  end

endmodule

// File: tb/tb_opb_register_snapshot_bank.sv
// Directed bench for the OPB register snapshot bank. dut_a uses defaults
// (no auto-snap); dut_b has auto-snap enabled and shares all inputs except
// its select line.
module tb_opb_register_snapshot_bank;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam logic [31:0] BASE = 32'h01100000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     abus;
  logic [3:0]      be;
  logic [31:0]     dbus;
  logic            rnw;
  logic            sel_a, sel_b;
  logic            seq_addr;
  logic [NCH*DW-1:0] user_data;
  logic [NCH-1:0]  user_valid;

  logic [31:0] dbus_a, dbus_b;
  logic        ack_a, ack_b;
  logic        err_a, retry_a, tout_a, err_b, retry_b, tout_b;

  logic        tgt;
  logic        ack_cur;
  logic [31:0] dbus_cur;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        acked;

  assign ack_cur  = tgt ? ack_b : ack_a;
  assign dbus_cur = tgt ? dbus_b : dbus_a;

  always #5 clk = ~clk;

  opb_register_snapshot_bank u_dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel_a),
    .OPB_seqAddr  (seq_addr),
    .Sl_DBus      (dbus_a),
    .Sl_xferAck   (ack_a),
    .Sl_errAck    (err_a),
    .Sl_retry     (retry_a),
    .Sl_toutSup   (tout_a),
    .user_data_in (user_data),
    .user_valid   (user_valid)
  );

  opb_register_snapshot_bank #(.C_AUTO_SNAP(1)) u_dut_b (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel_b),
    .OPB_seqAddr  (seq_addr),
    .Sl_DBus      (dbus_b),
    .Sl_xferAck   (ack_b),
    .Sl_errAck    (err_b),
    .Sl_retry     (retry_b),
    .Sl_toutSup   (tout_b),
    .user_data_in (user_data),
    .user_valid   (user_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer to the selected DUT; waits at most 8 cycles for the ack.
  // ack_valid is driven onto user_valid during the ack cycle only.
  task automatic bus_xfer(input logic rnw_i, input logic [31:0] addr_i,
                          input logic [31:0] data_i, input logic [3:0] be_i,
                          input logic [3:0] ack_valid,
                          output logic [31:0] rd_o, output logic acked_o);
    abus = addr_i; dbus = data_i; be = be_i; rnw = rnw_i;
    if (tgt) sel_b = 1'b1; else sel_a = 1'b1;
    acked_o = 1'b0;
    rd_o    = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack_cur) begin
        acked_o    = 1'b1;
        rd_o       = dbus_cur;
        user_valid = user_valid | ack_valid;
        break;
      end
    end
    tick();
    sel_a = 1'b0; sel_b = 1'b0; user_valid = '0; rnw = 1'b1; dbus = '0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr_i, input logic [31:0] exp);
    bus_xfer(1'b1, addr_i, '0, 4'b1111, '0, rd, acked);
    check({tag, "_ack"}, 32'(acked), 32'd1);
    check(tag, rd, exp);
  endtask

  task automatic write_reg(input string tag, input logic [31:0] addr_i, input logic [31:0] data_i,
                           input logic [3:0] be_i, input logic [3:0] ack_valid);
    bus_xfer(1'b0, addr_i, data_i, be_i, ack_valid, rd, acked);
    check({tag, "_ack"}, 32'(acked), 32'd1);
  endtask

  task automatic pulse(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      user_valid = mask;
      tick();
      user_valid = '0;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b1;
    sel_a = 1'b0; sel_b = 1'b0; seq_addr = 1'b0; tgt = 1'b0;
    user_data = '0; user_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_dbus", dbus_a, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_resp", {29'd0, err_a, retry_a, tout_a}, 32'd0);

    // INFO read: ack one cycle after select, data only in ack cycle
    abus = BASE + 32'h8; rnw = 1'b1; be = 4'b1111; sel_a = 1'b1;
    #1;
    check("info_req_ack", 32'(ack_a), 32'd0);
    tick();
    check("info_ack", 32'(ack_a), 32'd1);
    check("info_data", dbus_a, 32'h00020420);
    sel_a = 1'b0;
    tick();
    check("info_after_ack", 32'(ack_a), 32'd0);
    check("info_after_dbus", dbus_a, 32'd0);

    // CTRL: FREEZE readback, BE gating, SNAP/CLEAR read 0
    read_check("ctrl_init", BASE, 32'd0);
    write_reg("wr_freeze", BASE, 32'h7, 4'b1111, '0);
    read_check("ctrl_freeze", BASE, 32'h4);
    write_reg("wr_be_off", BASE, 32'h0, 4'b1110, '0);
    read_check("ctrl_be_off", BASE, 32'h4);
    write_reg("wr_ctrl0", BASE, 32'h0, 4'b0001, '0);
    read_check("ctrl_zero", BASE, 32'h0);

    // Five events on channel 2, then SNAP
    pulse(4'b0100, 5);
    write_reg("wr_snap1", BASE, 32'h1, 4'b1111, '0);
    read_check("cnt2_five", BASE + 32'h24, 32'd5);
    read_check("cnt0_zero", BASE + 32'h14, 32'd0);

    // Data snapshot on a non-auto bank stays put after live data changes
    user_data[1*DW +: DW] = 32'hA5A5A5A5;
    write_reg("wr_snap2", BASE, 32'h1, 4'b1111, '0);
    user_data[1*DW +: DW] = 32'h0;
    read_check("data1_snap", BASE + 32'h18, 32'hA5A5A5A5);

    // Read-only / unmapped words: acked, no effect, read zero
    write_reg("wr_status", BASE + 32'h4, 32'hFFFFFFFF, 4'b1111, '0);
    read_check("status_ro", BASE + 32'h4, 32'd0);
    read_check("unmapped_w3", BASE + 32'hC, 32'd0);
    read_check("chan4_w12", BASE + 32'h30, 32'd0);
    read_check("top_word", BASE + 32'hFC, 32'd0);
    bus_xfer(1'b1, BASE + 32'h100, '0, 4'b1111, '0, rd, acked);
    check("miss_high", 32'(acked), 32'd0);
    bus_xfer(1'b1, BASE - 32'h4, '0, 4'b1111, '0, rd, acked);
    check("miss_low", 32'(acked), 32'd0);

    // Saturation and sticky overflow on channel 2
    force u_dut.g_chan[2].u_chan.live_count = 32'hFFFFFFFE;
    #2;
    release u_dut.g_chan[2].u_chan.live_count;
    pulse(4'b0100, 3);
    write_reg("wr_snap3", BASE, 32'h1, 4'b1111, '0);
    read_check("cnt2_sat", BASE + 32'h24, 32'hFFFFFFFF);
    read_check("status_ovf", BASE + 32'h4, 32'h4);

    // SNAP+CLEAR with an event on channel 0 in the same cycle
    pulse(4'b0001, 2);
    write_reg("wr_snapclr", BASE, 32'h3, 4'b1111, 4'b0001);
    read_check("cnt0_old", BASE + 32'h14, 32'd2);
    read_check("cnt2_preclr", BASE + 32'h24, 32'hFFFFFFFF);
    read_check("status_clr", BASE + 32'h4, 32'd0);
    write_reg("wr_snap4", BASE, 32'h1, 4'b1111, '0);
    read_check("cnt0_cleared", BASE + 32'h14, 32'd0);
    read_check("cnt2_cleared", BASE + 32'h24, 32'd0);

    // Held select: ack on alternate cycles
    abus = BASE; rnw = 1'b1; sel_a = 1'b1;
    #1;
    check("hold_c0", 32'(ack_a), 32'd0);
    tick();
    check("hold_c1", 32'(ack_a), 32'd1);
    tick();
    check("hold_c2", 32'(ack_a), 32'd0);
    tick();
    check("hold_c3", 32'(ack_a), 32'd1);
    sel_a = 1'b0;
    tick();

    // Auto-snap bank: tracks, freezes, resumes within one cycle
    tgt = 1'b1;
    user_data[0 +: DW] = 32'h11;
    tick();
    tick();
    read_check("auto_track", BASE + 32'h10, 32'h11);
    write_reg("b_freeze", BASE, 32'h4, 4'b1111, '0);
    for (int k = 0; k < 5; k++) begin
      user_data[0 +: DW] = 32'h100 + 32'(k);
      tick();
    end
    read_check("auto_frozen", BASE + 32'h10, 32'h11);
    write_reg("b_unfreeze", BASE, 32'h0, 4'b1111, '0);
    user_data[0 +: DW] = 32'h55;
    tick();
    read_check("auto_resume", BASE + 32'h10, 32'h55);
    read_check("auto_cnt_nosnap", BASE + 32'h24, 32'd0);
    tgt = 1'b0;
    read_check("noauto_data0", BASE + 32'h10, 32'd0);

    // Load some state, then reset in the middle of a transfer
    user_data[3*DW +: DW] = 32'hDEAD;
    pulse(4'b1000, 1);
    write_reg("wr_pre_rst", BASE, 32'h5, 4'b1111, '0);
    read_check("cnt3_one", BASE + 32'h2C, 32'd1);
    read_check("data3_dead", BASE + 32'h28, 32'hDEAD);
    abus = BASE; rnw = 1'b1; sel_a = 1'b1;
    #4;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", 32'(ack_a), 32'd0);
    tick();
    check("rst_edge_ack", 32'(ack_a), 32'd0);
    sel_a = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ack", 32'(ack_a), 32'd0);
    check("post_rst_dbus", dbus_a, 32'd0);
    read_check("post_rst_ctrl", BASE, 32'd0);
    read_check("post_rst_status", BASE + 32'h4, 32'd0);
    for (int w = 4; w < 12; w++)
      read_check($sformatf("post_rst_w%0d", w), BASE + 32'(4 * w), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
